s_term_cfg_switch_matrix: RTL
=============================

S_TERM_CFG_SWITCH_MATRIX -- requirements
Module: s_term_cfg_switch_matrix

Interface
REQ-001 SHALL have parameter W1, default 4, width of S1END/N1BEG.
REQ-002 SHALL have parameter W2, default 8, width of S2MID/S2END/N2BEG/N2BEGb.
REQ-003 SHALL have parameter W4, default 16, width of S4END/SS4END/N4BEG/NN4BEG.
REQ-004 SHALL define localparam CFG_BITS = 11 and a 4-bit shift counter.
REQ-005 SHALL have ports:
 UserCLK  input  1  sole clock, rising edge
 UserRST  input  1  reset, synchronous, active-high
 cfg_data  input  1  serial config bit
 cfg_shift  input  1  shift cfg_data into shadow register this cycle
 cfg_commit  input  1  request copy of shadow to active config
 S1END  input  W1  single wires from north
 S2MID, S2END  input  W2 each  double wires, mid/end taps
 S4END, SS4END  input  W4 each  quad wires
 N1BEG  output  W1;  N2BEG, N2BEGb  output  W2;  N4BEG, NN4BEG  output  W4  loop-back wires
 Co0  output  1  carry-chain terminator
 cfg_err  output  1  sticky commit-length error
 cfg_active  output  CFG_BITS  active config readback
REQ-006 One clock, UserCLK; reset UserRST synchronous active-high; no other clock or async path.

Function
REQ-007 Groups: G0 S1END->N1BEG, G1 S2MID->N2BEG, G2 S2END->N2BEGb, G3 S4END->N4BEG, G4 SS4END->NN4BEG.
REQ-008 Active config bits: [1:0]=G0 mode, [3:2]=G1, [5:4]=G2, [7:6]=G3, [9:8]=G4, [10]=Co0 value.
REQ-009 Mode 00 reverse: out[i] = in[W-1-i], combinational, 0 latency.
REQ-010 Mode 01 straight: out[i] = in[i], combinational.
REQ-011 Mode 10 registered reverse: out[i] = pipeline reg capturing in[W-1-i], 1-cycle latency.
REQ-012 Mode 11 off: out = all zeros.
REQ-013 Pipeline regs capture reversed input every cycle regardless of mode; switching into mode 10 shows prior-cycle sample immediately.
REQ-014 Co0 = active[10] (0=GND, 1=VCC), combinational from active register.
REQ-015 cfg_shift=1 (no commit): shadow <= {shadow[9:0], cfg_data}; count <= min(count+1, 12).
REQ-016 cfg_commit=1 with count==11: active <= shadow; count <= 0; cfg_err unchanged.
REQ-017 cfg_commit=1 with count!=11: active unchanged; count <= 0; cfg_err <= 1.
REQ-018 cfg_commit and cfg_shift same cycle: commit evaluated on pre-edge count, shift ignored (no shadow change).
REQ-019 New active config drives outputs from the cycle after the commit edge; no partial update ever visible.
REQ-020 Count saturates at 12 (overlength); overlength commit is an error per REQ-017.
REQ-021 cfg_err clears only on reset; cfg_active = active register.

Reset
REQ-022 UserRST high at edge: active <= 0 (all groups reverse, Co0=0), shadow <= 0, count <= 0, cfg_err <= 0, pipeline regs <= 0.
REQ-023 Reset overrides simultaneous cfg_shift/cfg_commit; mid-shift reset discards partial load.
REQ-024 After reset, outputs equal legacy fixed terminal behaviour: reversed loop-back, Co0=0.

Verification
REQ-025 Post-reset, S4END=16'h0001 -> N4BEG=16'h8000, Co0=0, cfg_active=0, same cycle.
REQ-026 Shift 11 bits forming 11'b1_00_01_10_11_01, commit -> next cycle N1BEG=S1END, N2BEG=0, N2BEGb 1-cycle-delayed reverse, N4BEG=S4END, NN4BEG reverse, Co0=1, cfg_err=0.
REQ-027 Shift 10 bits then commit -> cfg_active unchanged, cfg_err=1, count=0; subsequent 11-bit load+commit succeeds, cfg_err stays 1.
REQ-028 Shift 13 bits then commit -> rejected, cfg_err=1; commit+shift same cycle after 11 bits -> accepted, shadow unchanged.
REQ-029 G2 mode 10: S2END steps 8'h01,8'h02 on consecutive cycles -> N2BEGb 8'h80 then 8'h40, each one cycle late.
REQ-030 Reset asserted after 5 shifts -> count 0, shadow 0; commit next cycle -> rejected, cfg_err=1.

Source files
------------

// File: rtl/s_term_cfg_switch_matrix.sv
// South-terminal loop-back switch matrix: five wire groups folded back north under
// an 11-bit serially loaded configuration with length-checked atomic commit.
module s_term_cfg_switch_matrix #(
    parameter int W1 = 4,
    parameter int W2 = 8,
    parameter int W4 = 16
) (
    input  logic          UserCLK,
    input  logic          UserRST,
    input  logic          cfg_data,
    input  logic          cfg_shift,
    input  logic          cfg_commit,
    input  logic [W1-1:0] S1END,
    input  logic [W2-1:0] S2MID,
    input  logic [W2-1:0] S2END,
    input  logic [W4-1:0] S4END,
    input  logic [W4-1:0] SS4END,
    output logic [W1-1:0] N1BEG,
    output logic [W2-1:0] N2BEG,
    output logic [W2-1:0] N2BEGb,
    output logic [W4-1:0] N4BEG,
    output logic [W4-1:0] NN4BEG,
    output logic          Co0,
    output logic          cfg_err,
    output logic [10:0]   cfg_active
);

    localparam int          CFG_BITS = 11;
    localparam logic [3:0]  CNT_FULL = 4'd11;
    localparam logic [3:0]  CNT_SAT  = 4'd12;

    typedef enum logic [1:0] {
        MODE_REV = 2'b00,
        MODE_STR = 2'b01,
        MODE_REG = 2'b10,
        MODE_OFF = 2'b11
    } mode_e;

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic [3:0]          count;
    logic                err_q;

    logic [W1-1:0] s1_rev,  s1_pipe;
    logic [W2-1:0] s2m_rev, s2m_pipe;
    logic [W2-1:0] s2e_rev, s2e_pipe;
    logic [W4-1:0] s4_rev,  s4_pipe;
    logic [W4-1:0] ss4_rev, ss4_pipe;

    for (genvar i = 0; i < W1; i++) begin : g_rev1
        assign s1_rev[i] = S1END[W1-1-i];
    end
    for (genvar i = 0; i < W2; i++) begin : g_rev2
        assign s2m_rev[i] = S2MID[W2-1-i];
        assign s2e_rev[i] = S2END[W2-1-i];
    end
    for (genvar i = 0; i < W4; i++) begin : g_rev4
        assign s4_rev[i]  = S4END[W4-1-i];
        assign ss4_rev[i] = SS4END[W4-1-i];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge UserCLK) begin
        if (UserRST) begin
            shadow   <= '0;
            active   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
            s1_pipe  <= '0;
            s2m_pipe <= '0;
            s2e_pipe <= '0;
            s4_pipe  <= '0;
            ss4_pipe <= '0;
        end else begin
            // Pipelines run every cycle so entering mode 10 shows the previous sample at once.
            s1_pipe  <= s1_rev;
            s2m_pipe <= s2m_rev;
            s2e_pipe <= s2e_rev;
            s4_pipe  <= s4_rev;
            ss4_pipe <= ss4_rev;
            if (cfg_commit) begin
                count <= '0;
                if (count == CNT_FULL) begin
                    active <= shadow;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (cfg_shift) begin
                shadow <= {shadow[CFG_BITS-2:0], cfg_data};
                if (count != CNT_SAT) begin
                    count <= count + 4'd1;
                end
            end
        end
    end

    mode_e m0, m1, m2, m3, m4;
    assign m0 = mode_e'(active[1:0]);
    assign m1 = mode_e'(active[3:2]);
    assign m2 = mode_e'(active[5:4]);
    assign m3 = mode_e'(active[7:6]);
    assign m4 = mode_e'(active[9:8]);

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        N1BEG  = '0;
        N2BEG  = '0;
        N2BEGb = '0;
        N4BEG  = '0;
        NN4BEG = '0;
        case (m0)
            MODE_REV: N1BEG = s1_rev;
            MODE_STR: N1BEG = S1END;
            MODE_REG: N1BEG = s1_pipe;
            default:  N1BEG = '0;
        endcase
        case (m1)
            MODE_REV: N2BEG = s2m_rev;
            MODE_STR: N2BEG = S2MID;
            MODE_REG: N2BEG = s2m_pipe;
            default:  N2BEG = '0;
        endcase
        case (m2)
            MODE_REV: N2BEGb = s2e_rev;
            MODE_STR: N2BEGb = S2END;
            MODE_REG: N2BEGb = s2e_pipe;
            default:  N2BEGb = '0;
        endcase
        case (m3)
            MODE_REV: N4BEG = s4_rev;
            MODE_STR: N4BEG = S4END;
            MODE_REG: N4BEG = s4_pipe;
            default:  N4BEG = '0;
        endcase
        case (m4)
            MODE_REV: NN4BEG = ss4_rev;
            MODE_STR: NN4BEG = SS4END;
            MODE_REG: NN4BEG = ss4_pipe;
            default:  NN4BEG = '0;
        endcase
    end

    assign Co0        = active[10];
    assign cfg_err    = err_q;
    assign cfg_active = active;

endmodule
